// File: rtl/dma_bus_arbiter_pkg.sv
// Shared definitions for the DMA bus-request handshake.
// Holds the 3-bit arbiter state encoding and the default timing limits.
// The cpu wrapper and the DMA model use the same encoding and limits.
package dma_bus_arbiter_pkg;

   typedef logic [2:0] arb_state_t;

   localparam arb_state_t ST_IDLE    = 3'd0;
   localparam arb_state_t ST_CMD     = 3'd1;
   localparam arb_state_t ST_ARB     = 3'd2;
   localparam arb_state_t ST_GRANT   = 3'd3;
   localparam arb_state_t ST_RELEASE = 3'd4;

   localparam int CMD_TIMEOUT_DEF = 16;
   localparam int MAX_GRANT_DEF   = 64;

endpackage

// File: rtl/dma_bus_arbiter_irq_latch.sv
// dma_irq_latch: sticky interrupt flag with set-over-acknowledge priority.
// Ports:
//   clk      in   clock
//   reset_n  in   synchronous, active-low reset (clears the flag)
//   set      in   raise the flag
//   ack      in   clear the flag unless set is high in the same cycle
//   flag     out  current flag value
module dma_irq_latch (
   input  logic clk,
   input  logic reset_n,
   input  logic set,
   input  logic ack,
   output logic flag
);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         flag <= 1'b0;
      end else if (set) begin
         flag <= 1'b1;
      end else if (ack) begin
         flag <= 1'b0;
      end
   end

endmodule

// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: CPU-side responder for the DMA bus-request handshake.
// Forwards the device start interrupt to the DMA as cmd, grants the bus
// (BG) only once the CPU data port is idle, stalls and isolates the CPU
// data port for the grant, and latches DMA completion as a CPU interrupt.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   dma_begin           device start pulse
//   dma_end             DMA completion pulse
//   BR                  bus request from the DMA
//   cpu_mem_busy        CPU memory stage access in flight
//   irq_ack             CPU acknowledge of the completion interrupt
//   cmd, BG             start command / bus grant to the DMA
//   cpu_stall           freeze CPU memory stage and upstream
//   cpu_dport_en        CPU may drive its data-memory port
//   irq_pending         sticky completion interrupt
//   err_cmd_timeout     sticky: BR never answered cmd
//   err_begin_overrun   sticky: dma_begin while busy
//   grant_overrun       sticky: grant longer than MAX_GRANT cycles
//   grant_cycles        length of the last completed grant (saturating)
module dma_bus_arbiter
   import dma_bus_arbiter_pkg::*;
#(
   parameter int CMD_TIMEOUT = CMD_TIMEOUT_DEF,
   parameter int MAX_GRANT   = MAX_GRANT_DEF,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             dma_begin,
   input  logic             dma_end,
   input  logic             BR,
   input  logic             cpu_mem_busy,
   input  logic             irq_ack,
   output logic             cmd,
   output logic             BG,
   output logic             cpu_stall,
   output logic             cpu_dport_en,
   output logic             irq_pending,
   output logic             err_cmd_timeout,
   output logic             err_begin_overrun,
   output logic             grant_overrun,
   output logic [CNT_W-1:0] grant_cycles
);

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(CMD_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   arb_state_t       state;
   logic             begin_pending;
   logic [CNT_W-1:0] tmo_cnt;
   logic [CNT_W-1:0] grant_cnt;
   logic             begin_ok;

   // A start is only accepted when nothing is queued or in progress.
   assign begin_ok = (state == ST_IDLE) && !begin_pending;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state             <= ST_IDLE;
         begin_pending     <= 1'b0;
         tmo_cnt           <= '0;
         grant_cnt         <= '0;
         err_cmd_timeout   <= 1'b0;
         err_begin_overrun <= 1'b0;
         grant_overrun     <= 1'b0;
         grant_cycles      <= '0;
      end else begin
         if (dma_begin) begin
            if (begin_ok) begin
               begin_pending <= 1'b1;
            end else begin
               err_begin_overrun <= 1'b1;
            end
         end

         case (state)
            ST_IDLE: begin
               if (begin_pending) begin
                  state         <= ST_CMD;
                  begin_pending <= 1'b0;
                  tmo_cnt       <= '0;
               end
            end
            ST_CMD: begin
               if (BR) begin
                  state <= ST_ARB;
               end else if (tmo_cnt == TMO_LAST) begin
                  state           <= ST_IDLE;
                  err_cmd_timeout <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end
            ST_ARB: begin
               // A withdrawn request wins over a free CPU port.
               if (!BR) begin
                  state <= ST_IDLE;
               end else if (!cpu_mem_busy) begin
                  state     <= ST_GRANT;
                  grant_cnt <= CNT_W'(1);
               end
            end
            ST_GRANT: begin
               // grant_cnt equals the number of grant cycles so far,
               // including the current one.
               if (32'(grant_cnt) > MAX_GRANT) begin
                  grant_overrun <= 1'b1;
               end
               if (!BR) begin
                  state        <= ST_RELEASE;
                  grant_cycles <= grant_cnt;
               end else begin
                  grant_cnt <= sat_inc(grant_cnt);
               end
            end
            ST_RELEASE: state <= ST_IDLE;
            default:    state <= ST_IDLE;
         endcase
      end
   end

   assign cmd          = (state == ST_CMD);
   assign BG           = (state == ST_GRANT);
   assign cpu_stall    = (state == ST_GRANT) || (state == ST_RELEASE);
   assign cpu_dport_en = !cpu_stall;

   dma_irq_latch u_irq_latch (
      .clk     (clk),
      .reset_n (reset_n),
      .set     (dma_end),
      .ack     (irq_ack),
      .flag    (irq_pending)
   );

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Testbench for dma_bus_arbiter: directed scenarios plus randomized traffic
// checked against a phase-level reference model.
module tb_dma_bus_arbiter;

   localparam int CMD_TIMEOUT = 16;
   localparam int MAX_GRANT   = 64;
   localparam int CNT_W       = 8;
   localparam int CNT_SAT     = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             dma_begin;
   logic             dma_end;
   logic             BR;
   logic             cpu_mem_busy;
   logic             irq_ack;
   logic             cmd;
   logic             BG;
   logic             cpu_stall;
   logic             cpu_dport_en;
   logic             irq_pending;
   logic             err_cmd_timeout;
   logic             err_begin_overrun;
   logic             grant_overrun;
   logic [CNT_W-1:0] grant_cycles;
   logic [15:0]      obs_vec;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dma_bus_arbiter #(
      .CMD_TIMEOUT (CMD_TIMEOUT),
      .MAX_GRANT   (MAX_GRANT),
      .CNT_W       (CNT_W)
   ) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .dma_begin         (dma_begin),
      .dma_end           (dma_end),
      .BR                (BR),
      .cpu_mem_busy      (cpu_mem_busy),
      .irq_ack           (irq_ack),
      .cmd               (cmd),
      .BG                (BG),
      .cpu_stall         (cpu_stall),
      .cpu_dport_en      (cpu_dport_en),
      .irq_pending       (irq_pending),
      .err_cmd_timeout   (err_cmd_timeout),
      .err_begin_overrun (err_begin_overrun),
      .grant_overrun     (grant_overrun),
      .grant_cycles      (grant_cycles)
   );

   assign obs_vec = {cmd, BG, cpu_stall, cpu_dport_en, irq_pending,
                     err_cmd_timeout, err_begin_overrun, grant_overrun, grant_cycles};

   // Reference model: the handshake as phases with remaining/elapsed cycle
   // counts (cmd counts down the remaining wait, grant counts cycles held).
   bit m_pend, m_arb, m_rel, m_irq, m_err_to, m_err_ov, m_gov;
   int m_cmd_left, m_grant, m_gcyc;

   task automatic model_reset();
      m_pend = 0; m_arb = 0; m_rel = 0; m_irq = 0;
      m_err_to = 0; m_err_ov = 0; m_gov = 0;
      m_cmd_left = 0; m_grant = 0; m_gcyc = 0;
   endtask

   task automatic model_step(input bit b, input bit e, input bit br, input bit busy, input bit ack);
      bit idle;
      bit p0;
      idle = (m_cmd_left == 0) && !m_arb && (m_grant == 0) && !m_rel;
      p0   = m_pend;
      if (b) begin
         if (idle && !p0) m_pend = 1;
         else m_err_ov = 1;
      end
      if (e) m_irq = 1;
      else if (ack) m_irq = 0;
      if (idle) begin
         if (p0) begin
            m_pend = 0;
            m_cmd_left = CMD_TIMEOUT;
         end
      end else if (m_cmd_left > 0) begin
         if (br) begin
            m_cmd_left = 0;
            m_arb = 1;
         end else if (m_cmd_left == 1) begin
            m_cmd_left = 0;
            m_err_to = 1;
         end else begin
            m_cmd_left--;
         end
      end else if (m_arb) begin
         if (!br) m_arb = 0;
         else if (!busy) begin
            m_arb = 0;
            m_grant = 1;
         end
      end else if (m_grant > 0) begin
         if (m_grant > MAX_GRANT) m_gov = 1;
         if (!br) begin
            m_gcyc = m_grant;
            m_grant = 0;
            m_rel = 1;
         end else begin
            m_grant = (m_grant + 1 > CNT_SAT) ? CNT_SAT : m_grant + 1;
         end
      end else begin
         m_rel = 0;
      end
   endtask

   function automatic logic [15:0] exp_vec();
      logic st;
      logic [7:0] gc;
      st = (m_grant > 0) || m_rel;
      gc = m_gcyc[7:0];
      return {m_cmd_left > 0, m_grant > 0, st, !st, m_irq, m_err_to, m_err_ov, m_gov, gc};
   endfunction

   task automatic step(input bit b, input bit e, input bit br, input bit busy, input bit ack);
      reset_n = 1'b1; dma_begin = b; dma_end = e; BR = br; cpu_mem_busy = busy; irq_ack = ack;
      model_step(b, e, br, busy, ack);
      @(posedge clk); #1;
   endtask

   task automatic rst_step();
      reset_n = 1'b0;
      dma_begin = 1'($urandom); dma_end = 1'($urandom); BR = 1'($urandom);
      cpu_mem_busy = 1'($urandom); irq_ack = 1'($urandom);
      model_reset();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_step();
      rst_step();
      checks++;
      if (obs_vec !== 16'h1000) begin
         failures++;
         $display("FAIL reset_state got=%h want=%h", obs_vec, 16'h1000);
      end
   endtask

   task automatic test_basic_transfer();
      int n_cmd = 0, n_bg = 0, n_stall = 0, n_dlow = 0, n_both = 0;
      rst_step();
      for (int k = 0; k < 18; k++) begin
         step(k == 0, k == 17, (k >= 3 && k <= 15), 1'b0, 1'b0);
         if (cmd) n_cmd++;
         if (BG) n_bg++;
         if (cpu_stall) n_stall++;
         if (!cpu_dport_en) n_dlow++;
         if (cmd && BG) n_both++;
      end
      checks++; if (n_cmd != 2)  begin failures++; $display("FAIL basic_cmd_cycles got=%0d want=2", n_cmd); end
      checks++; if (n_bg != 12)  begin failures++; $display("FAIL basic_bg_cycles got=%0d want=12", n_bg); end
      checks++; if (n_stall != 13) begin failures++; $display("FAIL basic_stall_cycles got=%0d want=13", n_stall); end
      checks++; if (n_dlow != 13) begin failures++; $display("FAIL basic_dport_off_cycles got=%0d want=13", n_dlow); end
      checks++; if (n_both != 0) begin failures++; $display("FAIL basic_cmd_bg_overlap got=%0d want=0", n_both); end
      checks++; if (grant_cycles !== 8'd12) begin failures++; $display("FAIL basic_grant_cycles got=%0d want=12", grant_cycles); end
      checks++; if (irq_pending !== 1'b1) begin failures++; $display("FAIL basic_irq_set got=%b want=1", irq_pending); end
      step(0, 0, 0, 0, 0);
      checks++; if (irq_pending !== 1'b1) begin failures++; $display("FAIL basic_irq_sticky got=%b want=1", irq_pending); end
      step(0, 0, 0, 0, 1);
      checks++; if (irq_pending !== 1'b0) begin failures++; $display("FAIL basic_irq_ack got=%b want=0", irq_pending); end
   endtask

   task automatic test_cpu_busy();
      rst_step();
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 1, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 1, 0);
         checks++;
         if (BG !== 1'b0 || cpu_stall !== 1'b0 || cpu_dport_en !== 1'b1) begin
            failures++;
            $display("FAIL busy_hold_%0d got BG=%b stall=%b dport=%b want 0/0/1", i, BG, cpu_stall, cpu_dport_en);
         end
      end
      step(0, 0, 1, 0, 0);
      checks++; if (BG !== 1'b1) begin failures++; $display("FAIL busy_grant got=%b want=1", BG); end
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      checks++; if (cpu_dport_en !== 1'b1) begin failures++; $display("FAIL busy_resume got=%b want=1", cpu_dport_en); end
   endtask

   task automatic test_cmd_timeout();
      int n_cmd = 0, n_bg = 0;
      rst_step();
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 22; i++) begin
         step(0, 0, 0, 1'($urandom), 0);
         if (cmd) n_cmd++;
         if (BG) n_bg++;
      end
      checks++; if (n_cmd != CMD_TIMEOUT) begin failures++; $display("FAIL timeout_cmd_cycles got=%0d want=%0d", n_cmd, CMD_TIMEOUT); end
      checks++; if (err_cmd_timeout !== 1'b1) begin failures++; $display("FAIL timeout_flag got=%b want=1", err_cmd_timeout); end
      checks++; if (n_bg != 0) begin failures++; $display("FAIL timeout_bg_cycles got=%0d want=0", n_bg); end
   endtask

   task automatic test_begin_overrun();
      int n_cmd = 0;
      rst_step();
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      checks++; if (err_begin_overrun !== 1'b0) begin failures++; $display("FAIL overrun_early got=%b want=0", err_begin_overrun); end
      step(1, 0, 1, 0, 0);
      checks++; if (err_begin_overrun !== 1'b1) begin failures++; $display("FAIL overrun_flag got=%b want=1", err_begin_overrun); end
      step(0, 0, 0, 0, 0);
      for (int i = 0; i < 30; i++) begin
         step(0, 0, 0, 0, 0);
         if (cmd) n_cmd++;
      end
      checks++; if (n_cmd != 0) begin failures++; $display("FAIL overrun_second_cmd got=%0d want=0", n_cmd); end
   endtask

   task automatic test_grant_overrun();
      int n_bg = 0;
      rst_step();
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      for (int n = 1; n <= 300; n++) begin
         step(0, 0, 1, (n == 1) ? 1'b0 : 1'($urandom), 0);
         if (BG) n_bg++;
         if (n == 65) begin
            checks++; if (grant_overrun !== 1'b0) begin failures++; $display("FAIL gov_at_65 got=%b want=0", grant_overrun); end
         end
         if (n == 66) begin
            checks++; if (grant_overrun !== 1'b1) begin failures++; $display("FAIL gov_at_66 got=%b want=1", grant_overrun); end
         end
      end
      checks++; if (n_bg != 300) begin failures++; $display("FAIL gov_bg_held got=%0d want=300", n_bg); end
      step(0, 0, 0, 0, 0);
      checks++; if (grant_cycles !== 8'd255) begin failures++; $display("FAIL gov_grant_sat got=%0d want=255", grant_cycles); end
      checks++; if (BG !== 1'b0 || cpu_stall !== 1'b1) begin failures++; $display("FAIL gov_release got BG=%b stall=%b want 0/1", BG, cpu_stall); end
      step(0, 0, 0, 0, 0);
      checks++; if (cpu_dport_en !== 1'b1) begin failures++; $display("FAIL gov_resume got=%b want=1", cpu_dport_en); end
   endtask

   task automatic test_reset_mid_grant_irq();
      step(1, 1, 0, 0, 0);
      checks++; if (irq_pending !== 1'b1) begin failures++; $display("FAIL both_pulses_irq got=%b want=1", irq_pending); end
      step(0, 0, 0, 0, 0);
      checks++; if (cmd !== 1'b1) begin failures++; $display("FAIL both_pulses_cmd got=%b want=1", cmd); end
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      step(1, 0, 1, 0, 0);
      checks++; if (BG !== 1'b1) begin failures++; $display("FAIL midgrant_bg got=%b want=1", BG); end
      rst_step();
      checks++;
      if (obs_vec !== 16'h1000) begin
         failures++;
         $display("FAIL midgrant_reset got=%h want=%h", obs_vec, 16'h1000);
      end
      step(0, 1, 1, 0, 1);
      checks++; if (irq_pending !== 1'b1) begin failures++; $display("FAIL irq_set_priority got=%b want=1", irq_pending); end
      checks++; if (cmd !== 1'b0 || BG !== 1'b0) begin failures++; $display("FAIL after_reset_idle got cmd=%b BG=%b want 0/0", cmd, BG); end
      step(0, 0, 0, 0, 1);
      checks++; if (irq_pending !== 1'b0) begin failures++; $display("FAIL irq_ack_after got=%b want=0", irq_pending); end
   endtask

   task automatic test_random();
      bit br_lvl = 0;
      int shown = 0;
      rst_step();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            rst_step();
         end else begin
            if ($urandom_range(0, 7) == 0) br_lvl = ~br_lvl;
            step($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, br_lvl,
                 1'($urandom), $urandom_range(0, 7) == 0);
         end
         checks++;
         if (obs_vec !== exp_vec()) begin
            failures++;
            if (shown < 20) begin
               shown++;
               $display("FAIL random_cycle_%0d got=%h want=%h", i, obs_vec, exp_vec());
            end
         end
      end
   endtask

   initial begin
      reset_n = 1'b0; dma_begin = 1'b0; dma_end = 1'b0;
      BR = 1'b0; cpu_mem_busy = 1'b0; irq_ack = 1'b0;
      model_reset();
      test_reset();
      test_basic_transfer();
      test_cpu_busy();
      test_cmd_timeout();
      test_begin_overrun();
      test_grant_overrun();
      test_reset_mid_grant_irq();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
